// File: rtl/wide_alu_pkg.sv
// Shared opcode/ALU-command encodings, FSM states and the (op, half) -> command map
// for the 64-bit sequencer built on the 32-bit EXE ALU.
package wide_alu_pkg;

    localparam logic [2:0] OP_MOV  = 3'd0;
    localparam logic [2:0] OP_MVN  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_ORR  = 3'd5;
    localparam logic [2:0] OP_EOR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Only ADD/SUB change command between halves, so the carry chains into the high word.
    function automatic logic [3:0] alu_cmd(input logic [2:0] op, input logic hi);
        logic [3:0] cmd;
        case (op)
            OP_MOV:  cmd = CMD_MOV;
            OP_MVN:  cmd = CMD_MVN;
            OP_ADD:  cmd = hi ? CMD_ADC : CMD_ADD;
            OP_SUB:  cmd = hi ? CMD_SBC : CMD_SUB;
            OP_AND:  cmd = CMD_AND;
            OP_ORR:  cmd = CMD_ORR;
            OP_EOR:  cmd = CMD_EOR;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/wide_alu_sequencer_if.sv
// Request/response handshake bundle between the requester (master) and the
// sequencer (slave).
interface wide_alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_res;
    logic [3:0]  rsp_nzcv;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_nzcv, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_nzcv, rsp_err, busy
    );
endinterface

// File: rtl/wide_alu_sequencer_alu.sv
// The existing single-cycle 32-bit EXE ALU. C reports carry for add and borrow for
// subtract; SBC subtracts ~status_in.
module wide_alu_sequencer_alu
    import wide_alu_pkg::*;
(
    input  logic [31:0] Val1_in,
    input  logic [31:0] Val2_in,
    input  logic [3:0]  EXE_CMD_in,
    input  logic        status_in,
    output logic [31:0] alu_res,
    output logic        n_out,
    output logic        z_out,
    output logic        c_out,
    output logic        v_out
);

    logic [32:0] sum;

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned infers a latch.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        c_out   = 1'b0;
        v_out   = 1'b0;
        case (EXE_CMD_in)
            CMD_MOV: alu_res = Val2_in;
            CMD_MVN: alu_res = ~Val2_in;
            CMD_ADD, CMD_ADC: begin
                sum     = {1'b0, Val1_in} + {1'b0, Val2_in}
                        + {32'b0, (EXE_CMD_in == CMD_ADC) & status_in};
                alu_res = sum[31:0];
                c_out   = sum[32];
                v_out   = (Val1_in[31] == Val2_in[31]) && (alu_res[31] != Val1_in[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum     = {1'b0, Val1_in} - {1'b0, Val2_in}
                        - {32'b0, (EXE_CMD_in == CMD_SBC) & ~status_in};
                alu_res = sum[31:0];
                c_out   = sum[32];
                v_out   = (Val1_in[31] != Val2_in[31]) && (alu_res[31] != Val1_in[31]);
            end
            CMD_AND: alu_res = Val1_in & Val2_in;
            CMD_ORR: alu_res = Val1_in | Val2_in;
            CMD_EOR: alu_res = Val1_in ^ Val2_in;
            default: alu_res = '0;
        endcase
    end

    assign n_out = alu_res[31];
    assign z_out = (alu_res == 32'd0);

endmodule

// File: rtl/wide_alu_sequencer.sv
// 64-bit operations on the shared 32-bit ALU: low word in LO, high word in HI with
// carry/borrow chained through status_in, registered response held in DONE.
module wide_alu_sequencer
    import wide_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    wide_alu_sequencer_if.slave  bus
);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        z_lo_q, z_lo_d, c_lo_q, c_lo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_res_q, rsp_res_d;
    logic [3:0]  rsp_nzcv_q, rsp_nzcv_d;
    logic        rsp_err_q, rsp_err_d;

    logic        half_hi;
    logic [31:0] alu_val1, alu_val2, alu_res;
    logic [3:0]  alu_cmd_in;
    logic        alu_status, alu_n, alu_z, alu_c, alu_v;

    // Half-select mux; the ALU reports borrow as C=1 while SBC subtracts
    // ~status_in, hence the inversion for SUB.
    always_comb begin
        half_hi    = (state_q == ST_HI);
        alu_val1   = half_hi ? a_q[63:32] : a_q[31:0];
        alu_val2   = half_hi ? b_q[63:32] : b_q[31:0];
        alu_cmd_in = alu_cmd(op_q, half_hi);
        alu_status = 1'b0;
        if (half_hi && op_q == OP_ADD) alu_status = c_lo_q;
        if (half_hi && op_q == OP_SUB) alu_status = ~c_lo_q;
    end

    wide_alu_sequencer_alu u_alu (
        .Val1_in    (alu_val1),
        .Val2_in    (alu_val2),
        .EXE_CMD_in (alu_cmd_in),
        .status_in  (alu_status),
        .alu_res    (alu_res),
        .n_out      (alu_n),
        .z_out      (alu_z),
        .c_out      (alu_c),
        .v_out      (alu_v)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_lo_d    = res_lo_q;
        z_lo_d      = z_lo_q;
        c_lo_d      = c_lo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_nzcv_d  = rsp_nzcv_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                op_d    = bus.req_op;
                a_d     = bus.req_a;
                b_d     = bus.req_b;
                c_lo_d  = 1'b0;
                state_d = ST_LO;
            end
            ST_LO: begin
                res_lo_d = alu_res;
                z_lo_d   = alu_z;
                c_lo_d   = alu_c;
                state_d  = ST_HI;
            end
            ST_HI: begin
                rsp_res_d   = {alu_res, res_lo_q};
                rsp_nzcv_d  = {alu_n, z_lo_q & alu_z, alu_c, alu_v};
                rsp_err_d   = (op_q == OP_RSVD);
                rsp_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge _d value regardless of statement order.
    // NOTE: the operand and partial-result registers are reset too; they are a
    // handful of flops, not a memory, and a clean reset keeps the outputs defined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MOV;
            a_q         <= '0;
            b_q         <= '0;
            res_lo_q    <= '0;
            z_lo_q      <= 1'b0;
            c_lo_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_nzcv_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_lo_q    <= res_lo_d;
            z_lo_q      <= z_lo_d;
            c_lo_q      <= c_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_nzcv_q  <= rsp_nzcv_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_nzcv  = rsp_nzcv_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Scoreboard bench for wide_alu_sequencer: expected responses queued at issue,
// popped and compared when rsp_valid appears.
module tb_wide_alu_sequencer;
    import wide_alu_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  nzcv;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    rsp_t sb[$];

    wide_alu_sequencer_if bif ();

    wide_alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent flat 64-bit reference: C is carry for ADD, borrow for SUB.
    function automatic rsp_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        rsp_t        e;
        logic [64:0] s;
        logic        c, v;
        e = '0;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            OP_MOV: e.res = b;
            OP_MVN: e.res = ~b;
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[63:0];
                c = s[64];
                v = (a[63] == b[63]) && (e.res[63] != a[63]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                e.res = s[63:0];
                c = (a < b);
                v = (a[63] != b[63]) && (e.res[63] != a[63]);
            end
            OP_AND: e.res = a & b;
            OP_ORR: e.res = a | b;
            OP_EOR: e.res = a ^ b;
            default: begin
                e.res = '0;
                e.err = 1'b1;
            end
        endcase
        e.nzcv = {e.res[63], e.res == 64'd0, c, v};
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns #1 after its acceptance edge (state LO).
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input rsp_t exp, input bit push);
        int n;
        if (push) sb.push_back(exp);
        bif.req_op    = op;
        bif.req_a     = a;
        bif.req_b     = b;
        bif.req_valid = 1'b1;
        n = 0;
        while (bif.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bif.req_ready, n);
        end
        tick();
        bif.req_valid = 1'b0;
    endtask

    // Waits for rsp_valid; cyc counts edges after the acceptance edge.
    task automatic get_rsp(output rsp_t o, output int cyc);
        cyc = 0;
        while (bif.rsp_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (cyc == 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b after 50 cycles, required 1", bif.rsp_valid);
        end
        o.res  = bif.rsp_res;
        o.nzcv = bif.rsp_nzcv;
        o.err  = bif.rsp_err;
    endtask

    task automatic test_reset;
        bif.req_valid = 1'b0;
        bif.req_op    = '0;
        bif.req_a     = '0;
        bif.req_b     = '0;
        bif.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({bif.rsp_valid, bif.rsp_err, bif.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: {valid,err,busy}=%b required 000", {bif.rsp_valid, bif.rsp_err, bif.busy});
        end
        n_cmp++;
        if (bif.rsp_res !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_res: got %h required 0", bif.rsp_res);
        end
        n_cmp++;
        if (bif.rsp_nzcv !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_nzcv: got %b required 0000", bif.rsp_nzcv);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bif.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", bif.req_ready);
        end
    endtask

    task automatic test_arith;
        vec_t vecs[10];
        rsp_t exp, o;
        int   cyc;
        vecs[0] = '{OP_ADD, 64'h00000000_FFFFFFFF, 64'h00000000_00000001, 64'h00000001_00000000, 4'b0000};
        vecs[1] = '{OP_SUB, 64'h00000001_00000000, 64'h00000000_00000001, 64'h00000000_FFFFFFFF, 4'b0000};
        vecs[2] = '{OP_SUB, 64'd5, 64'd5, 64'd0, 4'b0100};
        vecs[3] = '{OP_SUB, 64'd0, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 4'b1010};
        vecs[4] = '{OP_ADD, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 64'h80000000_00000000, 4'b1001};
        for (int i = 5; i < 10; i++) begin
            vecs[i].op = (i == 5) ? OP_MOV : (i == 6) ? OP_MVN : (i == 7) ? OP_AND
                       : (i == 8) ? OP_ORR : OP_SUB;
            vecs[i].a  = {$urandom(), $urandom()};
            vecs[i].b  = {$urandom(), $urandom()};
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                exp.res  = vecs[i].res;
                exp.nzcv = vecs[i].nzcv;
                exp.err  = 1'b0;
            end else begin
                exp = model(vecs[i].op, vecs[i].a, vecs[i].b);
            end
            issue(vecs[i].op, vecs[i].a, vecs[i].b, exp, 1'b1);
            get_rsp(o, cyc);
            exp = sb.pop_front();
            n_cmp++;
            if (o !== exp) begin
                n_fail++;
                $display("FAIL arith_%0d: got res=%h nzcv=%b err=%b required res=%h nzcv=%b err=%b",
                         i, o.res, o.nzcv, o.err, exp.res, exp.nzcv, exp.err);
            end
            // rsp_valid must first be seen after the third edge counting the acceptance edge.
            n_cmp++;
            if (cyc != 2) begin
                n_fail++;
                $display("FAIL latency_%0d: rsp_valid after %0d edges past acceptance, required 2", i, cyc);
            end
            tick();
            n_cmp++;
            if ({bif.req_ready, bif.rsp_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL release_%0d: {req_ready,rsp_valid}=%b required 10", i, {bif.req_ready, bif.rsp_valid});
            end
        end
    endtask

    task automatic test_backpressure_rsvd;
        rsp_t exp, o, snap;
        int   cyc;
        bif.rsp_ready = 1'b0;
        issue(OP_EOR, 64'hDEADBEEF_12345678, 64'hDEADBEEF_12345678,
              '{64'd0, 4'b0100, 1'b0}, 1'b1);
        get_rsp(snap, cyc);
        for (int k = 0; k < 10; k++) begin
            tick();
            o.res  = bif.rsp_res;
            o.nzcv = bif.rsp_nzcv;
            o.err  = bif.rsp_err;
            n_cmp++;
            if (o !== snap || bif.rsp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable_%0d: got valid=%b res=%h nzcv=%b required valid=1 res=%h nzcv=%b",
                         k, bif.rsp_valid, o.res, o.nzcv, snap.res, snap.nzcv);
            end
            n_cmp++;
            if ({bif.req_ready, bif.busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL hold_ready_%0d: {req_ready,busy}=%b required 01", k, {bif.req_ready, bif.busy});
            end
        end
        exp = sb.pop_front();
        n_cmp++;
        if (snap !== exp) begin
            n_fail++;
            $display("FAIL eor_self: got res=%h nzcv=%b err=%b required res=%h nzcv=%b err=%b",
                     snap.res, snap.nzcv, snap.err, exp.res, exp.nzcv, exp.err);
        end
        bif.rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if (bif.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: rsp_valid=%b required 0", bif.rsp_valid);
        end

        issue(OP_RSVD, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, '{64'd0, 4'b0100, 1'b1}, 1'b1);
        get_rsp(o, cyc);
        exp = sb.pop_front();
        n_cmp++;
        if (o !== exp) begin
            n_fail++;
            $display("FAIL reserved_op: got res=%h nzcv=%b err=%b required res=%h nzcv=%b err=%b",
                     o.res, o.nzcv, o.err, exp.res, exp.nzcv, exp.err);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        rsp_t exp, o;
        int   cyc;
        issue(OP_ADD, 64'h11111111_FFFFFFFF, 64'h22222222_00000001, '0, 1'b0);
        tick();
        n_cmp++;
        if (bif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy: busy=%b required 1 before reset", bif.busy);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bif.rsp_valid, bif.busy, bif.req_ready} !== 3'b001 || bif.rsp_res !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_state: {valid,busy,ready}=%b res=%h required 001 res=0",
                     {bif.rsp_valid, bif.busy, bif.req_ready}, bif.rsp_res);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (bif.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale_%0d: rsp_valid=%b required 0", k, bif.rsp_valid);
            end
        end
        exp = model(OP_ADD, 64'h0000FFFF_80000000, 64'h00000001_80000000);
        issue(OP_ADD, 64'h0000FFFF_80000000, 64'h00000001_80000000, exp, 1'b1);
        get_rsp(o, cyc);
        exp = sb.pop_front();
        n_cmp++;
        if (o !== exp) begin
            n_fail++;
            $display("FAIL post_reset_add: got res=%h nzcv=%b required res=%h nzcv=%b",
                     o.res, o.nzcv, exp.res, exp.nzcv);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure_rsvd();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
